// File: rtl/arb_pkg.sv
// Shared types and constants for the UART response arbiter: FSM states,
// source indices and default packet tag bytes.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic SRC_ASC = 1'b0;
  localparam logic SRC_STL = 1'b1;

  localparam logic [7:0] DEF_ASC_TAG = 8'h61;
  localparam logic [7:0] DEF_STL_TAG = 8'h73;

  function automatic logic [1:0] src_onehot(input logic src);
    return (src == SRC_STL) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/resp_watchdog.sv
// Stall watchdog: counts consecutive enabled cycles without valid and pulses
// o_expire in the cycle that reaches TIMEOUT_CYCLES.
module resp_watchdog #(
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  input  logic i_valid,
  input  logic i_handshake,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  assign o_expire = i_enable && !i_valid && (r_cnt == TERM);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || !i_enable || i_handshake || o_expire) begin
      r_cnt <= '0;
    end else if (!i_valid) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_response_arbiter.sv
// Packet-level round-robin arbiter sharing the UART TX byte stream between the
// ASC and STL response sources, with optional tag byte, truncation and stall release.
module uart_response_arbiter
  import arb_pkg::*;
#(
  parameter bit         HEADER_EN      = 1'b1,
  parameter logic [7:0] ASC_TAG        = DEF_ASC_TAG,
  parameter logic [7:0] STL_TAG        = DEF_STL_TAG,
  parameter int         TIMEOUT_CYCLES = 100_000,
  parameter int         MAX_PKT_BYTES  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       asc_valid,
  output logic       asc_ready,
  input  logic [7:0] asc_data,
  input  logic       asc_last,
  input  logic       stl_valid,
  output logic       stl_ready,
  input  logic [7:0] stl_data,
  input  logic       stl_last,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic [1:0] grant,
  output logic [7:0] timeout_count,
  output logic [7:0] trunc_count
);

  localparam int BW = $clog2(MAX_PKT_BYTES + 1);
  localparam logic [BW-1:0] LAST_IDX = BW'(MAX_PKT_BYTES - 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic          r_sel;
  logic          r_last_served;
  logic [1:0]    r_grant;
  logic [BW-1:0] r_byte_cnt;
  logic [7:0]    r_timeout_count;
  logic [7:0]    r_trunc_count;

  logic       w_src_valid;
  logic       w_src_last;
  logic [7:0] w_src_data;
  logic       w_any_valid;
  logic       w_pick_stl;
  logic       w_hs;
  logic       w_at_max;
  logic       w_trunc;
  logic       w_expire;
  logic       w_pkt_end;

  assign w_src_valid = (r_sel == SRC_STL) ? stl_valid : asc_valid;
  assign w_src_last  = (r_sel == SRC_STL) ? stl_last  : asc_last;
  assign w_src_data  = (r_sel == SRC_STL) ? stl_data  : asc_data;
  assign w_any_valid = asc_valid || stl_valid;

  // On a tie the source that was not served last wins.
  assign w_pick_stl = stl_valid && (!asc_valid || (r_last_served == SRC_ASC));

  assign w_hs      = (r_state == DATA) && w_src_valid && tx_ready;
  assign w_at_max  = (r_byte_cnt == LAST_IDX);
  assign w_trunc   = w_hs && !w_src_last && w_at_max;
  assign w_pkt_end = (w_hs && (w_src_last || w_at_max)) || w_expire;

  resp_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .i_enable   (r_state == DATA),
    .i_valid    (w_src_valid),
    .i_handshake(w_hs),
    .o_expire   (w_expire)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    asc_ready   = 1'b0;
    stl_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_valid) w_state_nxt = HEADER_EN ? HDR : DATA;
      end
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = (r_sel == SRC_STL) ? STL_TAG : ASC_TAG;
        if (tx_ready) w_state_nxt = DATA;
      end
      DATA: begin
        tx_valid  = w_src_valid;
        tx_data   = w_src_valid ? w_src_data : 8'h00;
        asc_ready = (r_sel == SRC_ASC) && tx_ready;
        stl_ready = (r_sel == SRC_STL) && tx_ready;
        if (w_pkt_end) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_sel           <= SRC_ASC;
      r_last_served   <= SRC_STL;
      r_grant         <= 2'b00;
      r_byte_cnt      <= '0;
      r_timeout_count <= 8'h00;
      r_trunc_count   <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && w_any_valid) begin
        r_sel   <= w_pick_stl;
        r_grant <= src_onehot(w_pick_stl);
      end
      // Truncation and stall release end a packet just like a last byte.
      if (w_pkt_end) begin
        r_last_served <= r_sel;
        r_grant       <= 2'b00;
        r_byte_cnt    <= '0;
      end else if (w_hs) begin
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end
      if (w_trunc && (r_trunc_count != 8'hFF)) r_trunc_count <= r_trunc_count + 8'd1;
      if (w_expire && (r_timeout_count != 8'hFF)) r_timeout_count <= r_timeout_count + 8'd1;
    end
  end

  assign grant         = r_grant;
  assign timeout_count = r_timeout_count;
  assign trunc_count   = r_trunc_count;

endmodule
